// File: rtl/adc_sequencer.sv
// adc_sequencer: convStart/busy/rd_cs handshake sequencer for the PMIC feedback ADC with timeout and overrun flags.
// Optional ADC_SEQ_AVG_EN: average four good conversions before updating sample.
module adc_sequencer #(
  parameter int PERIOD     = 64,
  parameter int CONV_PULSE = 2,
  parameter int RD_CYCLES  = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fault_clr,
  input  logic       busy,
  input  logic [7:0] adcVoltage,
  output logic       convStart,
  output logic       rd_cs,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       fault,
  output logic       overrun
);
  typedef enum logic [2:0] {IDLE, START, WAIT_RISE, WAIT_FALL, READ, DONE} state_t;
  localparam logic [15:0] PERIOD_LAST = 16'(PERIOD - 1);
  localparam logic [7:0]  CONV_LAST   = 8'(CONV_PULSE - 1);
  localparam logic [7:0]  RD_LAST     = 8'(RD_CYCLES - 1);
  localparam logic [7:0]  TO_LAST     = 8'(TIMEOUT - 1);
  state_t      state, stateNext;
  logic        busyMeta, busyS;
  logic [15:0] periodCnt;
  logic [7:0]  phaseCnt;
  logic        tick, timeout, convDone;
  assign tick = enable && periodCnt == '0;
  // phaseCnt restarts on every state change, so it times pulse widths and busy waits alike
  always_comb begin
    stateNext = state;
    timeout   = 1'b0;
    convDone  = 1'b0;
    case (state)
      IDLE:      stateNext = tick ? START : IDLE;
      START:     stateNext = phaseCnt == CONV_LAST ? WAIT_RISE : START;
      WAIT_RISE: begin
        timeout   = !busyS && phaseCnt == TO_LAST;
        stateNext = busyS ? WAIT_FALL : timeout ? IDLE : WAIT_RISE;
      end
      WAIT_FALL: begin
        timeout   = busyS && phaseCnt == TO_LAST;
        stateNext = !busyS ? READ : timeout ? IDLE : WAIT_FALL;
      end
      READ: begin
        convDone  = phaseCnt == RD_LAST;
        stateNext = convDone ? DONE : READ;
      end
      default:   stateNext = IDLE;
    endcase
    if (!enable) begin
      stateNext = IDLE;
      timeout   = 1'b0;
      convDone  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busyMeta  <= 1'b0;
      busyS     <= 1'b0;
      periodCnt <= '0;
      state     <= IDLE;
      phaseCnt  <= '0;
      convStart <= 1'b1;
      rd_cs     <= 1'b1;
      fault     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      busyMeta  <= busy;
      busyS     <= busyMeta;
      periodCnt <= !enable ? '0 : tick ? PERIOD_LAST : periodCnt - 1'b1;
      state     <= stateNext;
      phaseCnt  <= stateNext == state ? phaseCnt + 1'b1 : '0;
      convStart <= stateNext != START;
      rd_cs     <= stateNext != READ;
      fault     <= timeout | (fault & !fault_clr);
      overrun   <= (tick && state != IDLE) | (overrun & !fault_clr);
    end
  end
`ifdef ADC_SEQ_AVG_EN
  logic [9:0] acc, accSum;
  logic [1:0] avgCnt;
  assign accSum = acc + 10'(adcVoltage);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc          <= '0;
      avgCnt       <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= convDone && avgCnt == 2'd3;
      if (timeout || !enable) begin
        acc    <= '0;
        avgCnt <= '0;
      end else if (convDone) begin
        acc    <= avgCnt == 2'd3 ? '0 : accSum;
        avgCnt <= avgCnt + 2'd1;
        if (avgCnt == 2'd3) sample <= accSum[9:2];
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= convDone;
      if (convDone) sample <= adcVoltage;
    end
  end
`endif
endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer: table-driven and scoreboarded bench for adc_sequencer with a reactive ADC busy model.
module tb_adc_sequencer;
  logic       clk = 1'b0, reset = 1'b0, enable = 1'b0, fault_clr = 1'b0, busy = 1'b0;
  logic [7:0] adcVoltage = 8'h00;
  logic       convStart, rd_cs, sample_valid, fault, overrun;
  logic [7:0] sample;
  int         checks = 0, errors = 0, cyc = 0, busyLen = 10;
  logic [7:0] expQ[$];
  logic [7:0] lastExp = 8'h00;
  logic       lastPushed = 1'b0, prevValid = 1'b0;
  int         avgN = 0, avgSum = 0;
`ifdef ADC_SEQ_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif
  typedef struct { int busyLen; logic [7:0] data; logic [7:0] expSample; } vec_t;
  vec_t vecs[6];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  adc_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .fault_clr(fault_clr), .busy(busy),
    .adcVoltage(adcVoltage), .convStart(convStart), .rd_cs(rd_cs), .sample(sample),
    .sample_valid(sample_valid), .fault(fault), .overrun(overrun)
  );
  // ADC model: busy rises with convStart and stays high busyLen cycles; busyLen 0 = dead ADC
  always @(negedge convStart) begin
    if (busyLen > 0) begin
      busy = 1'b1;
      repeat (busyLen) @(posedge clk);
      #1 busy = 1'b0;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic expectConv(input logic [7:0] d);
    lastPushed = 1'b0;
    if (AVG) begin
      avgSum += d;
      avgN++;
      if (avgN == 4) begin
        lastExp = 8'(avgSum >> 2);
        expQ.push_back(lastExp);
        lastPushed = 1'b1;
        avgN = 0;
        avgSum = 0;
      end
    end else begin
      lastExp = d;
      expQ.push_back(d);
      lastPushed = 1'b1;
    end
  endtask
  task automatic avgClear();
    avgN = 0;
    avgSum = 0;
  endtask
  task automatic waitConv(input int maxCyc);
    int n = 0;
    while (convStart !== 1'b0 && n < maxCyc) begin @(posedge clk); #1; n++; end
    if (convStart !== 1'b0) begin
      checks++; errors++;
      $display("FAIL convStart wait: no start within %0d cycles", maxCyc);
    end
  endtask
  task automatic waitRdDone(input string name);
    int n = 0;
    while (rd_cs !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
    while (rd_cs === 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s: rd_cs window not seen within 200 cycles", name);
    end
  endtask
  // scoreboard: every strobe must match the oldest expected sample
  always @(negedge clk) begin
    if (reset && sample_valid) begin
      if (expQ.size() == 0) check("unexpected strobe", 1, 0);
      else check("scoreboard sample", sample, expQ.pop_front());
      if (prevValid) check("strobe width", 2, 1);
    end
    prevValid = reset && sample_valid;
  end
  initial begin
    int n, t0, t1, low;
    vecs[0] = '{10, 8'h00, 8'h00};
    vecs[1] = '{10, 8'hFF, 8'hFF};
    vecs[2] = '{20, 8'h10, 8'h10};
    vecs[3] = '{5,  8'h11, 8'h11};
    vecs[4] = '{30, 8'h12, 8'h12};
    vecs[5] = '{10, 8'h13, 8'h13};
    repeat (3) @(posedge clk);
    #1;
    check("reset convStart", convStart, 1);
    check("reset rd_cs", rd_cs, 1);
    check("reset sample", sample, 0);
    check("reset valid", sample_valid, 0);
    check("reset fault", fault, 0);
    check("reset overrun", overrun, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1;
    adcVoltage = 8'h5A;
    expectConv(8'h5A);
    @(posedge clk); #1;
    check("convStart low after enable", convStart, 0);
    t0 = cyc;
    @(posedge clk); #1;
    check("convStart 2nd low cycle", convStart, 0);
    @(posedge clk); #1;
    check("convStart released", convStart, 1);
    n = 0;
    while (rd_cs !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    low = 0;
    while (rd_cs === 1'b0 && low < 20) begin @(posedge clk); #1; low++; end
    check("rd_cs low width", low, 2);
    check("first sample", sample, lastExp);
    check("first valid", sample_valid, lastPushed);
    expectConv(8'h5A);
    waitConv(80);
    t1 = cyc;
    check("tick period", t1 - t0, 64);
    waitRdDone("second conv");
    foreach (vecs[i]) begin
      busyLen = vecs[i].busyLen;
      adcVoltage = vecs[i].data;
      expectConv(vecs[i].data);
      waitConv(80);
      waitRdDone($sformatf("vec%0d", i));
      check($sformatf("vec%0d sample", i), sample, AVG ? lastExp : vecs[i].expSample);
      check($sformatf("vec%0d valid", i), sample_valid, lastPushed);
    end
    busyLen = 0;
    adcVoltage = 8'hE7;
    waitConv(80);
    n = 0;
    while (fault !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    check("timeout latency", n, 257);
    check("sample kept on timeout", sample, lastExp);
    avgClear();
    busyLen = 10;
    adcVoltage = 8'h77;
    expectConv(8'h77);
    waitConv(80);
    waitRdDone("post-fault conv");
    check("fault sticky", fault, 1);
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    check("fault cleared", fault, 0);
    check("overrun cleared", overrun, 0);
    busyLen = 80;
    adcVoltage = 8'h3C;
    expectConv(8'h3C);
    waitConv(80);
    t0 = cyc;
    waitRdDone("overrun conv1");
    check("overrun set", overrun, 1);
    adcVoltage = 8'hC3;
    expectConv(8'hC3);
    waitConv(150);
    t1 = cyc;
    check("dropped tick interval", t1 - t0, 128);
    waitRdDone("overrun conv2");
    check("overrun sample", sample, lastExp);
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    check("overrun cleared again", overrun, 0);
    busyLen = 30;
    adcVoltage = 8'hEE;
    waitConv(150);
    repeat (10) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk); #1;
    check("disable convStart", convStart, 1);
    check("disable rd_cs", rd_cs, 1);
    low = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rd_cs !== 1'b1 || convStart !== 1'b1) low++;
    end
    check("idle while disabled", low, 0);
    avgClear();
    busyLen = 10;
    adcVoltage = 8'h99;
    expectConv(8'h99);
    enable = 1'b1;
    @(posedge clk); #1;
    check("restart on enable", convStart, 0);
    waitRdDone("re-enable conv");
    check("re-enable sample", sample, lastExp);
    busyLen = 5;
    adcVoltage = 8'h44;
    waitConv(100);
    n = 0;
    while (rd_cs !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    check("rd_cs low before reset", rd_cs, 0);
    #2 reset = 1'b0;
    #1;
    check("async convStart", convStart, 1);
    check("async rd_cs", rd_cs, 1);
    check("async sample", sample, 0);
    check("async valid", sample_valid, 0);
    check("async fault", fault, 0);
    check("async overrun", overrun, 0);
    repeat (3) @(posedge clk);
    check("scoreboard drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
